// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master system bus arbiter: state encoding and
// default geometry of the 16 MB word-addressed bus.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int AW_DEFAULT      = 22;   // word address, bus_addr[23:2]
  localparam int DW_DEFAULT      = 32;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/bus_arb_rr.sv
// Two-input round-robin picker: on a tie the master that was not granted last wins.
// Purely combinational so it can be chained or widened for more masters later.
module bus_arb_rr
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last);
    gnt[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master round-robin bus arbiter; grant is held for one whole transaction.
// Optional BUS_TIMEOUT_EN adds a watchdog that force-completes unacknowledged accesses.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_dout,
  output logic [DW-1:0] m0_din,
  output logic          m0_ack,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_dout,
  output logic [DW-1:0] m1_din,
  output logic          m1_ack,
  output logic          bus_stb,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_dout,
  input  logic [DW-1:0] bus_din,
  input  logic          bus_ack,
  output logic          bus_err
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_arb: TIMEOUT must be within 2..65535");
  end

  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;
  logic [1:0] gnt;

  bus_arb_rr u_rr (
    .req  ({m1_stb, m0_stb}),
    .last (last_reg),
    .gnt  (gnt)
  );

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_reg <= '0;
    else        tmo_cnt_reg <= tmo_cnt_next;
  end
`endif

  // Bus side and routing are combinational from the state so reset kills them at once.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    bus_stb    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_dout   = '0;
    m0_din     = '0;
    m0_ack     = 1'b0;
    m1_din     = '0;
    m1_ack     = 1'b0;
    bus_err    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (gnt[0]) begin
          state_next = GNT0;
          last_next  = 1'b0;
        end else if (gnt[1]) begin
          state_next = GNT1;
          last_next  = 1'b1;
        end
      end

      GNT0: begin
        bus_stb  = m0_stb;
        bus_we   = m0_we;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_din   = bus_din;
        m0_ack   = bus_ack;
        if (bus_ack || !m0_stb) begin
          state_next = IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_hit) begin
          m0_din     = '0;
          m0_ack     = 1'b1;
          bus_err    = 1'b1;
          state_next = IDLE;
        end
`endif
      end

      GNT1: begin
        bus_stb  = m1_stb;
        bus_we   = m1_we;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_din   = bus_din;
        m1_ack   = bus_ack;
        if (bus_ack || !m1_stb) begin
          state_next = IDLE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_hit) begin
          m1_din     = '0;
          m1_ack     = 1'b1;
          bus_err    = 1'b1;
          state_next = IDLE;
        end
`endif
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  // Counts granted cycles; zero on the first cycle of every grant.
  always_comb begin
    tmo_cnt_next = '0;
    if (state_reg != IDLE && state_next != IDLE) begin
      tmo_cnt_next = tmo_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb: single master, alternation, write
// routing, async reset, dropped strobe / stray ack, and the timeout behaviour.
module tb_bus_arb;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_stb, m0_we, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_dout, m1_dout;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_ack, m1_ack;
  logic          bus_stb, bus_we, bus_ack, bus_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_dout, bus_din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_arb #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_dout  (m0_dout),
    .m0_din   (m0_din),
    .m0_ack   (m0_ack),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_dout  (m1_dout),
    .m1_din   (m1_din),
    .m1_ack   (m1_ack),
    .bus_stb  (bus_stb),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_ack  (bus_ack),
    .bus_err  (bus_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dout = '0;
    m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dout = '0;
    bus_ack = 0; bus_din = '0;

    // Reset state
    #12;
    chk("rst_bus_stb", bus_stb, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;

    // Single master read, ack in cycle 3
    tick();
    m0_stb = 1; m0_we = 0; m0_addr = 22'h000100;
    #1 chk("sm_c0_bus_stb", bus_stb, 0);
    tick();
    chk("sm_c1_bus_stb", bus_stb, 1);
    chk("sm_c1_bus_addr", bus_addr, 22'h000100);
    chk("sm_c1_m1_ack", m1_ack, 0);
    tick();
    chk("sm_c2_bus_stb", bus_stb, 1);
    chk("sm_c2_m0_ack", m0_ack, 0);
    tick();
    bus_ack = 1; bus_din = 32'hDEADBEEF;
    #1;
    chk("sm_c3_bus_stb", bus_stb, 1);
    chk("sm_c3_m0_ack", m0_ack, 1);
    chk("sm_c3_m0_din", m0_din, 32'hDEADBEEF);
    chk("sm_c3_m1_ack", m1_ack, 0);
    chk("sm_c3_m1_din", m1_din, 0);
    tick();
    bus_ack = 0; m0_stb = 0;
    #1;
    chk("sm_c4_bus_stb", bus_stb, 0);
    chk("sm_c4_m0_ack", m0_ack, 0);

    // Simultaneous requests from reset: order m0,m1,m0,m1 with idle gaps
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m0_stb = 1; m0_addr = 22'h000010;
    m1_stb = 1; m1_addr = 22'h000020;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_bus_stb", bus_stb, 1);
      chk("alt_bus_addr", bus_addr, (i % 2 == 0) ? 22'h000010 : 22'h000020);
      bus_ack = 1; bus_din = 32'h0000_0A00 + 32'(i);
      #1;
      chk("alt_m0_ack", m0_ack, (i % 2 == 0) ? 1 : 0);
      chk("alt_m1_ack", m1_ack, (i % 2 == 0) ? 0 : 1);
      tick();
      bus_ack = 0;
      #1;
      chk("alt_gap_bus_stb", bus_stb, 0);
    end
    m0_stb = 0; m1_stb = 0;
    tick();

    // Write routing through master 1
    m1_stb = 1; m1_we = 1; m1_addr = 22'h3FFFF1; m1_dout = 32'h12345678;
    #1 chk("wr_idle_bus_we", bus_we, 0);
    tick();
    chk("wr_bus_we", bus_we, 1);
    chk("wr_bus_addr", bus_addr, 22'h3FFFF1);
    chk("wr_bus_dout", bus_dout, 32'h12345678);
    bus_ack = 1;
    #1;
    chk("wr_m1_ack", m1_ack, 1);
    chk("wr_m0_ack", m0_ack, 0);
    tick();
    bus_ack = 0; m1_stb = 0; m1_we = 0;
    #1;
    chk("wr_after_bus_we", bus_we, 0);
    chk("wr_after_bus_dout", bus_dout, 0);
    chk("wr_after_bus_addr", bus_addr, 0);

    // Reset mid-transaction (m0 granted last, so a tie would favour m1 without reset)
    tick();
    m0_stb = 1; m0_we = 1; m0_addr = 22'h000055; m0_dout = 32'hCAFEF00D;
    tick();
    chk("rm_pre_bus_stb", bus_stb, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_bus_stb", bus_stb, 0);
    chk("rm_bus_we", bus_we, 0);
    chk("rm_bus_addr", bus_addr, 0);
    chk("rm_bus_dout", bus_dout, 0);
    bus_ack = 1;
    #1 chk("rm_m0_ack", m0_ack, 0);
    bus_ack = 0;
    rst_n = 1'b1;
    m1_stb = 1; m1_addr = 22'h000066;
    tick();
    chk("rm_tie_bus_addr", bus_addr, 22'h000055);
    bus_ack = 1;
    tick();
    bus_ack = 0; m0_stb = 0; m0_we = 0; m1_stb = 0;
    tick();

    // Premature stb drop, then stray ack in IDLE
    m0_stb = 1; m0_addr = 22'h000077;
    tick();
    chk("drop_pre_bus_stb", bus_stb, 1);
    m0_stb = 0;
    #1;
    chk("drop_bus_stb", bus_stb, 0);
    chk("drop_m0_ack", m0_ack, 0);
    tick();
    bus_ack = 1; bus_din = 32'h5555AAAA;
    #1;
    chk("stray_m0_ack", m0_ack, 0);
    chk("stray_m1_ack", m1_ack, 0);
    chk("stray_m0_din", m0_din, 0);
    bus_ack = 0;
    tick();

    // Unacknowledged access: timeout (TIMEOUT=8) or indefinite stall
    m0_stb = 1; m0_addr = 22'h000099; bus_din = 32'hAAAA5555;
    tick();
    for (int c = 1; c < 8; c++) begin
      chk("to_wait_m0_ack", m0_ack, 0);
      chk("to_wait_bus_err", bus_err, 0);
      tick();
    end
`ifdef BUS_TIMEOUT_EN
    chk("to_m0_ack", m0_ack, 1);
    chk("to_bus_err", bus_err, 1);
    chk("to_m0_din", m0_din, 0);
    tick();
    m0_stb = 0;
    #1;
    chk("to_after_bus_stb", bus_stb, 0);
    chk("to_after_bus_err", bus_err, 0);
`else
    for (int c = 0; c < 4; c++) begin
      chk("stall_bus_stb", bus_stb, 1);
      chk("stall_m0_ack", m0_ack, 0);
      chk("stall_bus_err", bus_err, 0);
      tick();
    end
    bus_ack = 1;
    #1 chk("stall_end_m0_ack", m0_ack, 1);
    tick();
    bus_ack = 0; m0_stb = 0;
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Two-master arbiter for the 16 MB system bus (stb/we/addr/ack, 32-bit data, word address [23:2]).
- Sits between the master ports and the address decoder / slave mux.
- Master 0 is the CPU; master 1 is a future bus master (DMA, video fetch).
- Round-robin grant with registered decision; holds the grant for one complete transaction, i.e. until ack.

Parameters:
- AW, 22, word-address width (bus_addr[23:2]).
- DW, 32, data width.
- TIMEOUT, 255, cycles without ack before a forced error completion (used only with BUS_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous reset, active low
- m0_stb  in  1  master 0 request strobe, held until m0_ack
- m0_we  in  1  master 0 write enable
- m0_addr  in  AW  master 0 word address
- m0_dout  in  DW  master 0 write data
- m0_din  out  DW  master 0 read data
- m0_ack  out  1  master 0 acknowledge
- m1_stb, m1_we, m1_addr, m1_dout, m1_din, m1_ack: same as master 0, for master 1
- bus_stb  out  1  strobe to decoder
- bus_we  out  1  write enable to decoder
- bus_addr  out  AW  address to decoder
- bus_dout  out  DW  write data to slaves
- bus_din  in  DW  read data from slave mux
- bus_ack  in  1  acknowledge from slave mux
- bus_err  out  1  one-cycle pulse on a timeout completion; constant 0 without BUS_TIMEOUT_EN

Behaviour:
- Clock/reset: single clock clk. rst_n is asynchronous, active low.
- Reset values: state=IDLE, last=1 (so master 0 wins the first tie), timeout counter=0. All outputs 0.
- States: IDLE, GNT0, GNT1.
- IDLE, no request: stay in IDLE.
- IDLE, only mX_stb=1: go to GNTX.
- IDLE, both requesting: grant the master != last; go to GNTX and set last=X.
- Request latency: stb sampled in IDLE at cycle n gives bus_stb=1 at cycle n+1.
- GNTX, bus outputs: bus_stb=mX_stb, bus_we=mX_we, bus_addr=mX_addr, bus_dout=mX_dout.
- GNTX, read/ack routing: mX_din=bus_din and mX_ack=bus_ack, both combinational.
- GNTX, loser port: non-granted master sees din=0 and ack=0.
- GNTX exit on ack: when bus_ack=1, return to IDLE the next cycle. There is always one idle bus cycle between transactions. A master that keeps stb high after ack is re-arbitrated in IDLE.
- GNTX exit on dropped stb: if mX_stb=0 before ack (protocol violation), return to IDLE; bus_stb falls the same cycle.
- IDLE outputs: bus_stb=0, bus_we=0, bus_addr=0, bus_dout=0; both din=0, both ack=0.
- Stray ack: bus_ack while IDLE is ignored and not forwarded.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1. Worst-case wait is one full transaction of the other master plus 2 cycles.
- Reset mid-transaction: outputs drop immediately (asynchronously). The in-flight transaction is abandoned and no ack is delivered.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to GNTX and increments each GNTX cycle without bus_ack.
- When the counter reaches TIMEOUT-1 with no ack: pulse mX_ack=1 with mX_din=32'h00000000, pulse bus_err=1 for one cycle, return to IDLE.
- A real bus_ack in that same cycle takes precedence: normal completion, bus_err=0.
- Not defined: no counter; bus_err is tied to 0; an unacknowledged access stalls indefinitely, as the current single-master bus does.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2), AW/DW defaults, TIMEOUT default.
- One natural sub-module, bus_arb_rr: a two-input round-robin picker (req[1:0], last -> gnt[1:0]), purely combinational, reusable for future N-master extension.
- The timeout counter stays inline, guarded by the macro.

Test Plan:
- Single master: m0 reads addr 22'h000100, slave acks at cycle 3 with 32'hDEADBEEF -> m0_din=32'hDEADBEEF with m0_ack; m1_ack=0 throughout; bus_stb high in cycles 1..3.
- Simultaneous requests from reset: m0 and m1 raise stb in the same cycle, both held -> grant order m0, m1, m0, m1; one idle cycle between grants.
- Write routing: m1 writes 32'h12345678 to 22'h3FFFF1 while m0 idles -> bus_we=1, bus_addr=22'h3FFFF1, bus_dout=32'h12345678 during GNT1 only.
- Reset mid-transaction: rst_n low during GNT0 before ack -> all outputs 0 without waiting for a clock edge; after release, simultaneous requests grant m0 first.
- Premature stb drop / stray ack: m0 drops stb in GNT0 -> state is IDLE next cycle, no ack forwarded. bus_ack=1 in IDLE -> m0_ack=m1_ack=0.
- BUS_TIMEOUT_EN with TIMEOUT=8: slave never acks -> m0_ack and bus_err pulse on the 8th GNT0 cycle with m0_din=0, then IDLE. Without the macro -> stall persists, bus_err stays 0.
